// File: rtl/lucaz97_pkg.sv
// Shared types and constants for the scan-load guard and the core build it feeds.
package lucaz97_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        LOADED,
        RUN,
        ERROR
    } slg_state_t;

    localparam logic [7:0] CRC8_POLY = 8'h07;

    // Must match the core scan chain; MEM_SIZE at the top level is derived from it.
    localparam int SLG_CHAIN_LEN = 136;

    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic data_bit);
        logic fb;
        fb = crc[7] ^ data_bit;
        return {crc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/scan_load_guard_btn_debounce.sv
// Button conditioning: 2-flop synchronizer followed by a stability counter.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_pin,
    output logic btn_out
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            cnt     <= '0;
            btn_out <= 1'b0;
        end else begin
            sync1 <= btn_pin;
            sync2 <= sync1;
            if (sync2 == btn_out) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                btn_out <= !btn_out;
                cnt     <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/scan_load_guard.sv
// Conditions the TT pins for the accumulator core: registers the scan path, checks
// scan session length/CRC, and releases proc_en only after a complete load.
//
// state  | meaning
// IDLE   | after reset, nothing loaded, run requests ignored
// SCAN   | scan session in progress, counting bits and tracking CRC
// LOADED | last session was exactly CHAIN_LEN bits, core may run
// RUN    | proc_en asserted to the core
// ERROR  | last session was short or long, run requests ignored
module scan_load_guard
    import lucaz97_pkg::*;
#(
    parameter int CHAIN_LEN       = SLG_CHAIN_LEN,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scan_enable_n,
    input  logic       proc_enable_n,
    input  logic       scan_in_pin,
    input  logic       btn_pin,
    output logic       scan_enable,
    output logic       scan_in,
    output logic       proc_en,
    output logic       btn_out,
    output logic       load_ok,
    output logic       load_err,
    output logic [7:0] crc_out
);

    localparam int CW = $clog2(CHAIN_LEN + 2);
    localparam logic [CW-1:0] CNT_FULL = CW'(CHAIN_LEN);
    localparam logic [CW-1:0] CNT_OVF  = CW'(CHAIN_LEN + 1);

    slg_state_t    state, state_d;
    logic [CW-1:0] bit_cnt, bit_cnt_d;
    logic [7:0]    crc, crc_d;
    logic          load_ok_d, load_err_d;
    logic          scan_req, proc_req, scan_rise;

    assign scan_req  = !scan_enable_n;
    assign proc_req  = !proc_enable_n;
    // scan_enable holds last cycle's scan_req, so it doubles as the edge-detect flop.
    assign scan_rise = scan_req && !scan_enable;
    assign crc_out   = crc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            crc         <= 8'h00;
            load_ok     <= 1'b0;
            load_err    <= 1'b0;
            scan_enable <= 1'b0;
            scan_in     <= 1'b0;
            proc_en     <= 1'b0;
        end else begin
            state       <= state_d;
            bit_cnt     <= bit_cnt_d;
            crc         <= crc_d;
            load_ok     <= load_ok_d;
            load_err    <= load_err_d;
            scan_enable <= scan_req;
            scan_in     <= scan_in_pin;
            // Decoded from the next state so proc_en falls on the same edge scan_enable rises.
            proc_en     <= (state_d == RUN) && !scan_req;
        end
    end

    always_comb begin
        state_d    = state;
        bit_cnt_d  = bit_cnt;
        crc_d      = crc;
        load_ok_d  = load_ok;
        load_err_d = load_err;
        if (scan_rise) begin
            state_d    = SCAN;
            bit_cnt_d  = CW'(1);
            crc_d      = crc8_step(8'h00, scan_in_pin);
            load_ok_d  = 1'b0;
            load_err_d = 1'b0;
        end else begin
            case (state)
                SCAN: begin
                    if (scan_req) begin
                        if (bit_cnt != CNT_OVF) begin
                            bit_cnt_d = bit_cnt + CW'(1);
                        end
                        crc_d = crc8_step(crc, scan_in_pin);
                    end else if (bit_cnt == CNT_FULL) begin
                        state_d   = LOADED;
                        load_ok_d = 1'b1;
                    end else begin
                        state_d    = ERROR;
                        load_err_d = 1'b1;
                    end
                end
                LOADED: begin
                    if (proc_req && !scan_req) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (!proc_req) begin
                        state_d = LOADED;
                    end
                end
                default: begin
                    state_d = state;
                end
            endcase
        end
    end

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .clk    (clk),
        .rst    (rst),
        .btn_pin(btn_pin),
        .btn_out(btn_out)
    );

endmodule

// File: tb/tb_scan_load_guard.sv
// Self-checking bench for scan_load_guard: cycle scoreboard for the scan/run path,
// directed checks for session outcomes, CRC and button debounce timing.
module tb_scan_load_guard;

    localparam int CHAIN = 136;
    localparam int S_IDLE = 0, S_SCAN = 1, S_LOADED = 2, S_RUN = 3, S_ERROR = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scan_enable_n = 1'b1;
    logic       proc_enable_n = 1'b1;
    logic       scan_in_pin = 1'b0;
    logic       btn_pin = 1'b0;
    logic       scan_enable, scan_in, proc_en, btn_out, load_ok, load_err;
    logic [7:0] crc_out;

    always #5 clk = ~clk;

    scan_load_guard dut (
        .clk          (clk),
        .rst          (rst),
        .scan_enable_n(scan_enable_n),
        .proc_enable_n(proc_enable_n),
        .scan_in_pin  (scan_in_pin),
        .btn_pin      (btn_pin),
        .scan_enable  (scan_enable),
        .scan_in      (scan_in),
        .proc_en      (proc_en),
        .btn_out      (btn_out),
        .load_ok      (load_ok),
        .load_err     (load_err),
        .crc_out      (crc_out)
    );

    typedef struct packed {
        logic       se;
        logic       si;
        logic       pe;
        logic       ok;
        logic       err;
        logic [7:0] crc;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;

    int         m_state = S_IDLE;
    int         m_cnt = 0;
    logic [7:0] m_crc = 8'h00;
    logic       m_ok = 1'b0, m_err = 1'b0, m_prev = 1'b0;
    logic       btn_v = 1'b0;
    logic [7:0] pat = 8'hA5;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] crc_bit(input logic [7:0] c, input logic b);
        logic [7:0] n;
        n = {c[6:0], 1'b0};
        if (c[7] ^ b) n = n ^ 8'h07;
        return n;
    endfunction

    // Byte-wise CRC-8 over n bytes of 0xA5, MSB first.
    function automatic logic [7:0] crc_ref(input int nbytes);
        logic [7:0] c;
        c = 8'h00;
        for (int k = 0; k < nbytes; k++) begin
            c = c ^ 8'hA5;
            for (int j = 0; j < 8; j++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c;
    endfunction

    function automatic logic pat_bit(input int i);
        return pat[7 - (i % 8)];
    endfunction

    task automatic step(input logic r, input logic sn, input logic pn, input logic si);
        exp_t e;
        logic sr, pr;
        rst = r;
        scan_enable_n = sn;
        proc_enable_n = pn;
        scan_in_pin = si;
        btn_pin = btn_v;
        sr = !sn;
        pr = !pn;
        e = '0;
        if (r) begin
            m_state = S_IDLE; m_cnt = 0; m_crc = 8'h00;
            m_ok = 1'b0; m_err = 1'b0; m_prev = 1'b0;
        end else begin
            if (sr && !m_prev) begin
                m_state = S_SCAN; m_cnt = 1; m_crc = crc_bit(8'h00, si);
                m_ok = 1'b0; m_err = 1'b0;
            end else begin
                case (m_state)
                    S_SCAN: begin
                        if (sr) begin
                            if (m_cnt < CHAIN + 1) m_cnt++;
                            m_crc = crc_bit(m_crc, si);
                        end else if (m_cnt == CHAIN) begin
                            m_state = S_LOADED; m_ok = 1'b1;
                        end else begin
                            m_state = S_ERROR; m_err = 1'b1;
                        end
                    end
                    S_LOADED: if (pr && !sr) m_state = S_RUN;
                    S_RUN:    if (!pr) m_state = S_LOADED;
                    default:  ;
                endcase
            end
            m_prev = sr;
            e.se = sr; e.si = si; e.pe = (m_state == S_RUN);
            e.ok = m_ok; e.err = m_err; e.crc = m_crc;
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("scan_enable", 8'(scan_enable), 8'(e.se));
        check("scan_in", 8'(scan_in), 8'(e.si));
        check("proc_en", 8'(proc_en), 8'(e.pe));
        check("load_ok", 8'(load_ok), 8'(e.ok));
        check("load_err", 8'(load_err), 8'(e.err));
        check("crc_out", crc_out, e.crc);
    endtask

    task automatic scan_session(input int nbits);
        for (int i = 0; i < nbits; i++) step(1'b0, 1'b0, 1'b1, pat_bit(i));
        step(1'b0, 1'b1, 1'b1, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int rise_at, fall_at;
        logic seen;

        // reset, then run request without a load
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        check("rst_btn_out", 8'(btn_out), 8'h00);
        check("rst_bit_cnt", 8'(dut.bit_cnt), 8'h00);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
        check("idle_proc_en", 8'(proc_en), 8'h00);

        // good 136-bit load, then run
        scan_session(CHAIN);
        check("good_load_ok", 8'(load_ok), 8'h01);
        check("good_load_err", 8'(load_err), 8'h00);
        check("good_crc_ref", crc_out, crc_ref(CHAIN / 8));
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check("run_proc_en", 8'(proc_en), 8'h01);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        check("pause_proc_en", 8'(proc_en), 8'h00);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check("resume_proc_en", 8'(proc_en), 8'h01);
        step(1'b0, 1'b1, 1'b1, 1'b0);

        // short and long sessions
        scan_session(CHAIN - 1);
        check("short_err", 8'(load_err), 8'h01);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
        check("short_proc_en", 8'(proc_en), 8'h00);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        scan_session(CHAIN + 1);
        check("long_err", 8'(load_err), 8'h01);
        check("long_cnt_sat", 8'(dut.bit_cnt), 8'(CHAIN + 1));
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
        check("long_proc_en", 8'(proc_en), 8'h00);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        scan_session(CHAIN);
        check("recover_ok", 8'(load_ok), 8'h01);

        // scan start while running
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check("run2_proc_en", 8'(proc_en), 8'h01);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("prio_proc_en", 8'(proc_en), 8'h00);
        check("prio_scan_en", 8'(scan_enable), 8'h01);
        check("prio_bit_cnt", 8'(dut.bit_cnt), 8'h01);
        check("prio_load_ok", 8'(load_ok), 8'h00);
        step(1'b0, 1'b1, 1'b1, 1'b0);

        // reset in the middle of a session
        for (int i = 0; i < 60; i++) step(1'b0, 1'b0, 1'b1, pat_bit(i));
        step(1'b1, 1'b1, 1'b1, 1'b0);
        check("midrst_scan_en", 8'(scan_enable), 8'h00);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
        check("midrst_proc_en", 8'(proc_en), 8'h00);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        scan_session(CHAIN);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check("reload_proc_en", 8'(proc_en), 8'h01);
        step(1'b0, 1'b1, 1'b1, 1'b0);

        // button glitch, clean press, clean release
        seen = 1'b0;
        btn_v = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 1'b1, 1'b0);
            seen = seen | btn_out;
        end
        btn_v = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b1, 1'b1, 1'b0);
            seen = seen | btn_out;
        end
        check("btn_glitch", 8'(seen), 8'h00);
        rise_at = 0;
        btn_v = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            step(1'b0, 1'b1, 1'b1, 1'b0);
            if (btn_out && rise_at == 0) rise_at = k;
        end
        check("btn_rise_lat", 8'(rise_at), 8'd18);
        fall_at = 0;
        btn_v = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            step(1'b0, 1'b1, 1'b1, 1'b0);
            if (!btn_out && fall_at == 0) fall_at = k;
        end
        check("btn_fall_lat", 8'(fall_at), 8'd18);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
